// File: rtl/imu_frame_pkg.sv
// Shared types and defaults for the IMU frame deserializer.
package imu_frame_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int          WORD_W_DEF          = 16;
  localparam logic [15:0] SYNC_WORD_DEF       = 16'hA55A;
  localparam int          WORDS_PER_FRAME_DEF = 6;
  localparam int          IDX_W               = 3;

endpackage

// File: rtl/imu_frame_deserializer_sipo_shift_reg.sv
// Enabled serial-in shift register; o_next is the value the register takes on an enabled edge.
module sipo_shift_reg #(
  parameter int WORD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_si,
  output logic [WORD_W-1:0] o_next
);

  logic [WORD_W-1:0] r_sh;

  assign o_next = {r_sh[WORD_W-2:0], i_si};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh <= '0;
    end else if (i_en) begin
      r_sh <= i_clr ? '0 : o_next;
    end
  end

endmodule

// File: rtl/imu_frame_deserializer.sv
// Sync-hunting IMU frame receiver with a valid/ready word output.
// Optional trailing checksum word enabled by defining FRAME_CHECKSUM_EN.
module imu_frame_deserializer
  import imu_frame_pkg::*;
#(
  parameter int                WORD_W          = WORD_W_DEF,
  parameter int                WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD       = SYNC_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on,
  input  logic              si,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_done,
`ifdef FRAME_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic              overrun
);

  localparam int               CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
`ifdef FRAME_CHECKSUM_EN
  // The checksum occupies the slot after the last data word.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
`endif

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [IDX_W-1:0]  r_word_cnt;
  logic [WORD_W-1:0] r_word_out;
  logic [IDX_W-1:0]  r_word_idx;
  logic              r_valid;
  logic              r_frame_done;
  logic              r_overrun;
`ifdef FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
  logic              r_chk_err;
`endif

  logic [WORD_W-1:0] w_next;
  logic              w_word_done;
  logic              w_frame_end;
  logic              w_is_data;
  logic              w_can_load;

  assign w_word_done = on && (r_state == DATA) && (r_bit_cnt == LAST_BIT);
  assign w_frame_end = w_word_done && (r_word_cnt == LAST_IDX);
  assign w_can_load  = !r_valid || word_ready;
`ifdef FRAME_CHECKSUM_EN
  assign w_is_data   = (r_word_cnt != LAST_IDX);
`else
  assign w_is_data   = 1'b1;
`endif

  // Clearing on frame end keeps trailing data bits from forming a false sync.
  sipo_shift_reg #(.WORD_W(WORD_W)) u_sipo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (on),
    .i_clr  (w_frame_end),
    .i_si   (si),
    .o_next (w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= HUNT;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_word_out   <= '0;
      r_word_idx   <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_sum        <= '0;
      r_chk_err    <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_chk_err    <= 1'b0;
`endif
      if (r_valid && word_ready) begin
        r_valid <= 1'b0;
      end
      if (on) begin
        if (r_state == HUNT) begin
          if (w_next == SYNC_WORD) begin
            r_state    <= DATA;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (w_is_data) begin
`ifdef FRAME_CHECKSUM_EN
              r_sum <= r_sum + w_next;
`endif
              // A load on the draining edge overrides the valid clear above.
              if (w_can_load) begin
                r_word_out <= w_next;
                r_word_idx <= r_word_cnt;
                r_valid    <= 1'b1;
              end else begin
                r_overrun  <= 1'b1;
              end
            end
            if (r_word_cnt == LAST_IDX) begin
              r_state      <= HUNT;
              r_frame_done <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
              r_chk_err    <= (w_next != r_sum);
`endif
            end
          end
        end
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_idx   = r_word_idx;
  assign word_valid = r_valid;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
`ifdef FRAME_CHECKSUM_EN
  assign chk_err    = r_chk_err;
`endif

endmodule

// File: tb/tb_imu_frame_deserializer.sv
// Scoreboard bench for imu_frame_deserializer; also covers FRAME_CHECKSUM_EN when defined.
module tb_imu_frame_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic        si;
  logic        word_ready;
  logic [15:0] word_out;
  logic [2:0]  word_idx;
  logic        word_valid;
  logic        frame_done;
  logic        overrun;
`ifdef FRAME_CHECKSUM_EN
  logic        chk_err;
  logic [15:0] cs_bias = 16'h0000;
  int          ce_cnt  = 0;
`endif

  typedef struct packed {
    logic [2:0]  i;
    logic [15:0] w;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] fw[6];
  int          n_vec   = 0;
  int          n_err   = 0;
  int          fd_cnt  = 0;
  int          cyc     = 0;
  int          lat     = 0;
  logic        v0      = 1'b0;
  int          fd_base = 0;

  imu_frame_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .on         (on),
    .si         (si),
    .word_out   (word_out),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_done (frame_done),
`ifdef FRAME_CHECKSUM_EN
    .chk_err    (chk_err),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: consume handshaken words against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {13'd0, word_idx, word_out}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("word_out", {16'd0, word_out}, {16'd0, mon_e.w});
          chk("word_idx", {29'd0, word_idx}, {29'd0, mon_e.i});
        end
      end
      if (frame_done) begin
        fd_cnt++;
`ifndef FRAME_CHECKSUM_EN
        chk("fd_with_valid", {31'd0, word_valid}, 32'd1);
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      if (chk_err) begin
        ce_cnt++;
        chk("ce_with_fd", {31'd0, frame_done}, 32'd1);
      end
`endif
    end
  end

  task automatic idle(input int n);
    on = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_bit(input logic b);
    si = b;
    on = 1'b1;
    @(posedge clk);
    #1;
    on = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic gap);
    for (int b = 15; b >= 0; b--) begin
      if (gap) idle(1);
      step_bit(w[b]);
    end
  endtask

  task automatic send_tail(input logic gap);
`ifdef FRAME_CHECKSUM_EN
    logic [15:0] s;
    s = 16'h0000;
    for (int k = 0; k < 6; k++) s = s + fw[k];
    send_word(s + cs_bias, gap);
`else
    if (gap) idle(0);
`endif
  endtask

  // Sync plus six words from fw; optionally push expectations.
  task automatic send_frame(input logic gap, input logic push);
    int t0;
    send_word(16'hA55A, gap);
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      if (push) sb.push_back(exp_t'{i: 3'(k), w: fw[k]});
      send_word(fw[k], gap);
      if (k == 0) begin
        lat = cyc - t0;
        v0  = word_valid;
      end
    end
    send_tail(gap);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 64 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; on = 1'b0; si = 1'b0; word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_word_out",   {16'd0, word_out},   32'd0);
    chk("rst_word_idx",   {29'd0, word_idx},   32'd0);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_overrun",    {31'd0, overrun},    32'd0);
`ifdef FRAME_CHECKSUM_EN
    chk("rst_chk_err",    {31'd0, chk_err},    32'd0);
`endif
    rst = 1'b0;
    idle(2);

    // Reset mid-frame, then a clean frame of 1..6
    word_ready = 1'b1;
    send_word(16'hA55A, 1'b0);
    step_bit(1'b1); step_bit(1'b0); step_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, word_valid}, 32'd0);
    idle(1);
    rst = 1'b0;
    idle(1);
    for (int k = 0; k < 6; k++) fw[k] = 16'(k + 1);
    fd_base = fd_cnt;
    send_frame(1'b0, 1'b1);
    wait_drain("midrst_drain");
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    chk("midrst_fd_once", fd_cnt - fd_base, 32'd1);

    // Noise before sync
    fw[0] = 16'h1234; fw[1] = 16'hBEEF; fw[2] = 16'hCAFE;
    fw[3] = 16'h0F0F; fw[4] = 16'h8001; fw[5] = 16'h7FFE;
    idle(3);
    send_word(16'hFFFF, 1'b0);
    fd_base = fd_cnt;
    send_frame(1'b0, 1'b1);
    wait_drain("noise_drain");
    chk("noise_latency", lat, 32'd16);
    chk("noise_v0", {31'd0, v0}, 32'd1);
    idle(3);
    chk("noise_fd_once", fd_cnt - fd_base, 32'd1);

    // on toggling every cycle
    for (int k = 0; k < 6; k++) fw[k] = 16'(k + 1);
    send_frame(1'b1, 1'b1);
    wait_drain("gate_drain");
    chk("gate_latency", lat, 32'd32);
    chk("gate_v0", {31'd0, v0}, 32'd1);
    chk("gate_overrun", {31'd0, overrun}, 32'd0);

    // Drain/load collision on word 2
    fw[0] = 16'h0101; fw[1] = 16'h0202; fw[2] = 16'h0303;
    fw[3] = 16'h0404; fw[4] = 16'h0505; fw[5] = 16'h0606;
    idle(2);
    word_ready = 1'b1;
    send_word(16'hA55A, 1'b0);
    sb.push_back(exp_t'{i: 3'd0, w: fw[0]});
    send_word(fw[0], 1'b0);
    sb.push_back(exp_t'{i: 3'd1, w: fw[1]});
    step_bit(fw[1][15]);
    word_ready = 1'b0;
    for (int b = 14; b >= 0; b--) step_bit(fw[1][b]);
    sb.push_back(exp_t'{i: 3'd2, w: fw[2]});
    for (int b = 15; b >= 1; b--) step_bit(fw[2][b]);
    chk("coll_held_valid", {31'd0, word_valid}, 32'd1);
    chk("coll_held_idx",   {29'd0, word_idx},   32'd1);
    word_ready = 1'b1;
    step_bit(fw[2][0]);
    chk("coll_valid", {31'd0, word_valid}, 32'd1);
    chk("coll_word",  {16'd0, word_out},   {16'd0, fw[2]});
    chk("coll_ovr",   {31'd0, overrun},    32'd0);
    for (int k = 3; k < 6; k++) begin
      sb.push_back(exp_t'{i: 3'(k), w: fw[k]});
      send_word(fw[k], 1'b0);
    end
    send_tail(1'b0);
    wait_drain("coll_drain");
    chk("coll_ovr_end", {31'd0, overrun}, 32'd0);

`ifdef FRAME_CHECKSUM_EN
    // Checksum good then bad
    for (int k = 0; k < 6; k++) fw[k] = 16'(k + 1);
    idle(2);
    cs_bias = 16'h0000;
    send_frame(1'b0, 1'b1);
    idle(3);
    chk("cs_good", ce_cnt, 32'd0);
    cs_bias = 16'h0001;
    send_frame(1'b0, 1'b1);
    idle(3);
    chk("cs_bad", ce_cnt, 32'd1);
    wait_drain("cs_drain");
    cs_bias = 16'h0000;
`endif

    // Backpressure for the whole frame
    for (int k = 0; k < 6; k++) fw[k] = 16'(k + 1);
    idle(2);
    word_ready = 1'b0;
    sb.push_back(exp_t'{i: 3'd0, w: 16'h0001});
    send_word(16'hA55A, 1'b0);
    send_word(fw[0], 1'b0);
    chk("bp_ovr_w0", {31'd0, overrun}, 32'd0);
    send_word(fw[1], 1'b0);
    chk("bp_ovr_w1", {31'd0, overrun}, 32'd1);
    for (int k = 2; k < 6; k++) send_word(fw[k], 1'b0);
    send_tail(1'b0);
    idle(2);
    chk("bp_word",  {16'd0, word_out},   32'h0001);
    chk("bp_idx",   {29'd0, word_idx},   32'd0);
    chk("bp_valid", {31'd0, word_valid}, 32'd1);
    chk("bp_ovr",   {31'd0, overrun},    32'd1);
    word_ready = 1'b1;
    wait_drain("bp_drain");
    idle(2);
    chk("bp_valid_drop", {31'd0, word_valid}, 32'd0);
    chk("bp_ovr_sticky", {31'd0, overrun},    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imu_frame_deserializer.md
# imu_frame_deserializer

Serial-to-parallel receiver that consumes the MSB-first 16-bit bitstream produced by the IMU word serializer and rebuilds framed sample words. It hunts for a 16-bit sync word, then captures a fixed number of data words per frame and presents each on a valid/ready output port to the OBC packet logic. Bits advance only on clock edges where `on` is high, matching the serializer's gating.

## Interface
Parameters:
- `WORD_W`, 16: word width in bits.
- `WORDS_PER_FRAME`, 6: data words per frame (ax, ay, az, gx, gy, gz).
- `SYNC_WORD`, 16'hA55A: frame marker.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `on`  input  1  bit enable; one serial bit is consumed per `clk` edge with `on`=1.
- `si`  input  1  serial data in, MSB first.
- `word_out`  output  16  captured data word.
- `word_idx`  output  3  index of `word_out` within the frame, 0..WORDS_PER_FRAME-1.
- `word_valid`  output  1  `word_out`/`word_idx` valid.
- `word_ready`  input  1  consumer accepts the word when high together with `word_valid`.
- `frame_done`  output  1  one-cycle pulse after the last word of a frame is captured.
- `overrun`  output  1  sticky; set when a completed word is dropped. Cleared only by `rst`.
- `chk_err`  output  1  one-cycle pulse, present only with `FRAME_CHECKSUM_EN`.

## Operation
- Reset: state HUNT, shift register 0, bit counter 0, word counter 0. `word_out`=0, `word_idx`=0, `word_valid`=0, `frame_done`=0, `overrun`=0, `chk_err`=0.
- Shift: on each edge with `on`=1, `sh <= {sh[14:0], si}`. With `on`=0, state, counters and `sh` hold.
- HUNT: compare `{sh[14:0], si}` to `SYNC_WORD` on each enabled edge. On a match, go to DATA, clear the bit counter and word counter. Overlapping or partial matches are not tracked beyond the sliding compare.
- DATA: the bit counter counts 0..15. On the enabled edge where the count is 15, the word `{sh[14:0], si}` is complete:
  - If the output holding register is empty, or is being drained this same cycle (`word_valid && word_ready`), load it, set `word_valid`=1 and set `word_idx` to the word counter.
  - Otherwise, drop the word, set `overrun`=1, and leave the held word untouched.
  - In both cases, increment the word counter.
- When the last data word completes (or the checksum word, if enabled), pulse `frame_done` on the next cycle. Return to HUNT with `sh` cleared to 0, so frame data cannot alias the sync word.
- Output handshake: `word_valid` stays high and `word_out`/`word_idx` stay stable until `word_valid && word_ready`. `word_valid` then drops the next cycle, unless a new word loads on that same edge.
- `rst` asserted mid-frame aborts immediately to the reset state; any partial word is discarded.

## Timing
- Latency: `word_valid` rises on the same `clk` edge that samples the 16th bit of a word, and is visible in the cycle after that edge.
- Sync-to-first-word: 16 enabled edges after the edge that completed the sync.
- Throughput: one word per 16 enabled edges. A consumer holding `word_ready`=1 never causes `overrun`.
- `frame_done` is registered and asserts the cycle after the final word's edge. It coincides with `word_valid` rising for that word.
- Simultaneous drain and load: accept the new word, no overrun, `word_valid` stays 1.

## Configuration
- `FRAME_CHECKSUM_EN` defined: one extra 16-bit word follows the data words.
  - The received checksum is compared with the mod-2^16 sum of the frame's data words.
  - On a mismatch, `chk_err` pulses together with `frame_done`.
  - The checksum word is never presented on `word_out`.
- `FRAME_CHECKSUM_EN` undefined: no checksum word is expected, `frame_done` follows data word WORDS_PER_FRAME-1, and the `chk_err` port is absent.

## Structure
- Package `imu_frame_pkg`:
  - state enum {HUNT, DATA}
  - `WORD_W`, `SYNC_WORD` default, and `WORDS_PER_FRAME` default
  - width constant for `word_idx`
- Sub-module `sipo_shift_reg`: a 16-bit enabled shift register exposing `{sh[14:0], si}` as the next value. The top level owns the FSM, counters, output register and checksum.

## Test plan
- Reset mid-frame: assert `rst` after 3 data bits, then send sync 16'hA55A plus 6 words 16'h0001..16'h0006 → words appear with `word_idx` 0..5, `overrun`=0.
- Noise before sync: send 16'hFFFF, then 16'hA55A, then words 16'h1234, 16'hBEEF, ... → the first `word_out`=16'h1234 with `word_idx`=0, and `frame_done` pulses once after word 5.
- `on` gating: toggle `on` 1/0 every cycle during a frame → identical words captured, with latency doubled in `clk` cycles.
- Backpressure: hold `word_ready`=0 for the whole frame → `word_out` stays 16'h0001 (first word), `overrun`=1 at word 1 and stays set.
- Drain/load collision: raise `word_ready` exactly on the edge completing word 2 → word 2 loads, `word_valid` never drops, `overrun`=0.
- With `FRAME_CHECKSUM_EN`: send words 1..6 followed by checksum 16'h0015 → `chk_err`=0. Then send checksum 16'h0016 → `chk_err` pulses with `frame_done`.
